sw8_in: RTL and testbench

- Memory-mapped 8-bit input peripheral; the input-direction counterpart of the LED8 output port.
- Samples 8 external switch/button pins, then synchronizes and debounces them.
- Latches each stable change into a data register and raises a sticky valid flag for the CPU to poll.
- Top level decodes CPU read of 0x0000_03f4 as data_reg and read of 0x0000_03f0 as state_reg.
- Top level pulses ack for one cycle on each read of 0x0000_03f4.

---
 rtl/sw8_in_pkg.sv | 17 +
 rtl/sync2ff.sv | 23 ++
 rtl/sw8_in.sv | 98 +++++++++
 tb/tb_sw8_in.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw8_in_pkg.sv
// Shared definitions for the sw8_in switch/button input port: FSM encoding,
// CPU register addresses and state_reg bit positions.
package sw8_in_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } sw_state_e;

  localparam logic [31:0] SW_DATA_ADDR  = 32'h0000_03f4;
  localparam logic [31:0] SW_STATE_ADDR = 32'h0000_03f0;

  localparam int VALID_BIT   = 0;
  localparam int OVERRUN_BIT = 1;
  localparam int BUSY_BIT    = 2;

endpackage

// File: rtl/sync2ff.sv
// Parameterised-width two-flop synchronizer with asynchronous active-high reset.
module sync2ff #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      q     <= '0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/sw8_in.sv
// 8-bit debounced input port: synchronizes raw pins, commits a value once it has
// been stable for a full window, and exposes data/valid/overrun/busy to the CPU.
module sw8_in
  import sw8_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_pins,
  input  logic        ack,
  output logic [31:0] data_reg,
  output logic [31:0] state_reg,
  output logic        change_irq
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [7:0]       sync2;
  logic [7:0]       candidate;
  logic [7:0]       data;
  logic [CNT_W-1:0] counter;
  logic             valid;
  logic             overrun;
  logic             commit;
  sw_state_e        state;

  sync2ff #(.W(8)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (in_pins),
    .q     (sync2)
  );

  // The load cycle counts as the first stable sample, so the window closes on the
  // edge where the counter steps onto its terminal value.
  always_comb begin
    commit = (state == COUNT) && (sync2 == candidate) &&
             (counter == PRE_LAST) && (candidate != data);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      candidate  <= '0;
      counter    <= '0;
      data       <= '0;
      valid      <= 1'b0;
      overrun    <= 1'b0;
      change_irq <= 1'b0;
    end else begin
      change_irq <= commit;
      if (commit) data <= candidate;

      if (commit)   valid <= 1'b1;
      else if (ack) valid <= 1'b0;

      if (commit && valid && !ack) overrun <= 1'b1;
      else if (ack)                overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (sync2 != data) begin
            candidate <= sync2;
            counter   <= '0;
            state     <= COUNT;
          end
        end
        COUNT: begin
          if (sync2 != candidate) begin
            candidate <= sync2;
            counter   <= '0;
          end else if (counter == PRE_LAST) begin
            // Window complete: commit (if it differs from data) or glitch rejected.
            counter <= LAST_CNT;
            state   <= IDLE;
          end else if (counter != LAST_CNT) begin
            counter <= counter + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    data_reg               = {24'b0, data};
    state_reg              = '0;
    state_reg[VALID_BIT]   = valid;
    state_reg[OVERRUN_BIT] = overrun;
    state_reg[BUSY_BIT]    = (state == COUNT);
  end

  a_cnt_fits: assert property (@(posedge clock) disable iff (reset)
    (DEBOUNCE_CYCLES >= 2) && (DEBOUNCE_CYCLES <= (1 << CNT_W)));

endmodule

// File: tb/tb_sw8_in.sv
// Self-checking bench for sw8_in with a short debounce window and a run-length
// reference model of the debouncer.
module tb_sw8_in;

  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_pins = 8'h00;
  logic        ack = 1'b0;
  logic [31:0] data_reg;
  logic [31:0] state_reg;
  logic        change_irq;

  int n_checks = 0;
  int n_fail   = 0;

  sw8_in #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_pins    (in_pins),
    .ack        (ack),
    .data_reg   (data_reg),
    .state_reg  (state_reg),
    .change_irq (change_irq)
  );

  always #5 clock = ~clock;

  // Reference model: a value is committed when the synchronized pins have held
  // the same value for exactly D samples and that value differs from the data.
  logic [7:0] s1_m = 8'h00, s2_m = 8'h00, prev_m = 8'h00, data_m = 8'h00;
  logic [7:0] samp_m;
  logic       valid_m = 1'b0, ovr_m = 1'b0, irq_m = 1'b0, busy_m = 1'b0, commit_m;
  int         run_m = D + 1;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_m = 8'h00; s2_m = 8'h00; prev_m = 8'h00; data_m = 8'h00;
      valid_m = 1'b0; ovr_m = 1'b0; irq_m = 1'b0; busy_m = 1'b0;
      run_m = D + 1;
    end else begin
      samp_m = s2_m;
      if (samp_m == prev_m) begin
        if (run_m <= D) run_m = run_m + 1;
      end else begin
        run_m = 1;
      end
      prev_m   = samp_m;
      commit_m = (run_m == D) && (samp_m != data_m);
      irq_m    = commit_m;
      if (commit_m && valid_m && !ack) ovr_m = 1'b1;
      else if (ack)                    ovr_m = 1'b0;
      if (commit_m)  valid_m = 1'b1;
      else if (ack)  valid_m = 1'b0;
      if (commit_m) data_m = samp_m;
      busy_m = (run_m < D);
      s2_m = s1_m;
      s1_m = in_pins;
    end
  end

  wire [64:0] obs_v = {state_reg, data_reg, change_irq};
  wire [64:0] exp_v = {29'b0, busy_m, ovr_m, valid_m, 24'b0, data_m, irq_m};

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_ack;
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic settle(input logic [7:0] v);
    in_pins = v;
    repeat (10) step();
    pulse_ack();
  endtask

  task automatic test_reset;
    int irqs;
    irqs = 0;
    reset = 1'b1;
    in_pins = 8'hA5;
    repeat (3) step();
    n_checks++;
    if (data_reg !== 32'h0 || state_reg !== 32'h0 || change_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got data=%h state=%h irq=%b expected 0/0/0", data_reg, state_reg, change_irq);
    end
    reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (change_irq) irqs++;
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_release k=%0d: got %h expected %h", k, obs_v, exp_v);
      end
      n_checks++;
      if (k < 6 && (data_reg !== 32'h0 || state_reg[0] !== 1'b0)) begin
        n_fail++;
        $display("FAIL reset_early k=%0d: got data=%h state=%h expected 0", k, data_reg, state_reg);
      end else if (k == 6 && (data_reg !== 32'h0000_00A5 || state_reg !== 32'h1 || change_irq !== 1'b1)) begin
        n_fail++;
        $display("FAIL reset_commit: got data=%h state=%h irq=%b expected a5/1/1", data_reg, state_reg, change_irq);
      end
    end
    n_checks++;
    if (irqs != 1) begin
      n_fail++;
      $display("FAIL reset_irq_count: got %0d expected 1", irqs);
    end
  endtask

  task automatic test_clean_step;
    settle(8'h00);
    in_pins = 8'h3C;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL clean_step k=%0d: got %h expected %h", k, obs_v, exp_v);
      end
      n_checks++;
      if (k >= 3 && k <= 5 && state_reg[2] !== 1'b1) begin
        n_fail++;
        $display("FAIL clean_busy k=%0d: got %b expected 1", k, state_reg[2]);
      end else if (k == 6 && (data_reg !== 32'h3C || state_reg !== 32'h1 || change_irq !== 1'b1)) begin
        n_fail++;
        $display("FAIL clean_commit: got data=%h state=%h irq=%b expected 3c/1/1", data_reg, state_reg, change_irq);
      end
    end
    pulse_ack();
    n_checks++;
    if (state_reg !== 32'h0 || obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL clean_ack: got %h expected %h (state 0)", obs_v, exp_v);
    end
  endtask

  task automatic test_bounce;
    logic [7:0] sched [4];
    int irqs;
    sched = '{8'h01, 8'h01, 8'h00, 8'h01};
    irqs = 0;
    settle(8'h00);
    for (int k = 1; k <= 12; k++) begin
      in_pins = sched[(k < 4) ? k - 1 : 3];
      step();
      if (change_irq) irqs++;
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL bounce k=%0d: got %h expected %h", k, obs_v, exp_v);
      end
      n_checks++;
      if ((k < 9 && data_reg !== 32'h0) || (k == 9 && (data_reg !== 32'h1 || change_irq !== 1'b1))) begin
        n_fail++;
        $display("FAIL bounce_timing k=%0d: got data=%h irq=%b", k, data_reg, change_irq);
      end
    end
    n_checks++;
    if (irqs != 1) begin
      n_fail++;
      $display("FAIL bounce_irq_count: got %0d expected 1", irqs);
    end
    settle(8'h00);
    irqs = 0;
    for (int k = 1; k <= 10; k++) begin
      in_pins = (k == 1) ? 8'h80 : 8'h00;
      step();
      if (change_irq) irqs++;
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL glitch k=%0d: got %h expected %h", k, obs_v, exp_v);
      end
    end
    n_checks++;
    if (irqs != 0 || data_reg !== 32'h0) begin
      n_fail++;
      $display("FAIL glitch_reject: got irqs=%0d data=%h expected 0/0", irqs, data_reg);
    end
  endtask

  task automatic test_overrun;
    for (int k = 1; k <= 16; k++) begin
      in_pins = (k <= 8) ? 8'h11 : 8'h22;
      step();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL overrun k=%0d: got %h expected %h", k, obs_v, exp_v);
      end
    end
    n_checks++;
    if (state_reg !== 32'h3 || data_reg !== 32'h22) begin
      n_fail++;
      $display("FAIL overrun_flags: got state=%h data=%h expected 3/22", state_reg, data_reg);
    end
    pulse_ack();
    n_checks++;
    if (state_reg !== 32'h0) begin
      n_fail++;
      $display("FAIL overrun_ack: got %h expected 0", state_reg);
    end
  endtask

  task automatic test_ack_commit;
    in_pins = 8'h55;
    repeat (8) step();
    in_pins = 8'h66;
    repeat (8) step();
    n_checks++;
    if (state_reg !== 32'h3) begin
      n_fail++;
      $display("FAIL ackc_setup: got %h expected 3", state_reg);
    end
    in_pins = 8'hAA;
    for (int k = 1; k <= 8; k++) begin
      ack = (k == 6);
      step();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL ack_commit k=%0d: got %h expected %h", k, obs_v, exp_v);
      end
      n_checks++;
      if (k == 6 && (state_reg !== 32'h1 || data_reg !== 32'hAA)) begin
        n_fail++;
        $display("FAIL ack_commit_flags: got state=%h data=%h expected 1/aa", state_reg, data_reg);
      end
    end
    ack = 1'b0;
    pulse_ack();
  endtask

  task automatic test_reset_mid_count;
    settle(8'h00);
    in_pins = 8'h0F;
    repeat (4) step();
    n_checks++;
    if (state_reg !== 32'h4) begin
      n_fail++;
      $display("FAIL midrst_busy: got %h expected 4", state_reg);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (state_reg !== 32'h0 || data_reg !== 32'h0 || change_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: got state=%h data=%h irq=%b expected 0", state_reg, data_reg, change_irq);
    end
    repeat (2) step();
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL midrst_release k=%0d: got %h expected %h", k, obs_v, exp_v);
      end
      n_checks++;
      if ((k < 6 && data_reg !== 32'h0) || (k == 6 && data_reg !== 32'h0F)) begin
        n_fail++;
        $display("FAIL midrst_commit k=%0d: got %h", k, data_reg);
      end
    end
  endtask

  task automatic test_random;
    int hold;
    for (int seg = 0; seg < 60; seg++) begin
      in_pins = ($urandom_range(0, 2) == 0) ? data_m : 8'($urandom_range(0, 255));
      hold = $urandom_range(1, 8);
      for (int k = 0; k < hold; k++) begin
        ack = ($urandom_range(0, 4) == 0);
        step();
        n_checks++;
        if (obs_v !== exp_v) begin
          n_fail++;
          $display("FAIL random seg=%0d: got %h expected %h", seg, obs_v, exp_v);
        end
      end
    end
    ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_bounce();
    test_overrun();
    test_ack_commit();
    test_random();
    test_reset_mid_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
